// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares DMEM port B between the CPU load/store path and the debug loader
module dmem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic [3:0]        dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              enb,
  output logic [3:0]        web,
  output logic [ADDR_W-1:0] addrb,
  output logic [31:0]       dib,
  input  logic [31:0]       dob
);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;
  state_t        state;
  logic          own_dbg, prio_cpu, cpu_win, dbg_win, done, unused;
  logic [CW-1:0] cnt;
  assign unused = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0], dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};
  // grant only in IDLE outside reset; on a tie the requester not granted last wins
  always_comb begin
    done       = state == DONE && !rst;
    cpu_win    = state == IDLE && !rst && cpu_req && (!dbg_req || prio_cpu);
    dbg_win    = state == IDLE && !rst && dbg_req && (!cpu_req || !prio_cpu);
    enb        = cpu_win || dbg_win;
    web        = cpu_win ? cpu_we : dbg_win ? dbg_we : 4'b0;
    addrb      = cpu_win ? cpu_addr[ADDR_W+1:2] : dbg_win ? dbg_addr[ADDR_W+1:2] : '0;
    dib        = cpu_win ? cpu_wdata : dbg_win ? dbg_wdata : 32'b0;
    dbg_gnt    = dbg_win;
    cpu_rvalid = done && !own_dbg;
    dbg_rvalid = done && own_dbg;
    cpu_stall  = cpu_req && !((cpu_win && |cpu_we) || cpu_rvalid);
  end
  // read sequencer: count out the BRAM latency, capture dob for the owner, then one bubble cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own_dbg   <= 1'b0;
      prio_cpu  <= 1'b1;
      cnt       <= '0;
      cpu_rdata <= 32'b0;
      dbg_rdata <= 32'b0;
    end else if (state == IDLE) begin
      if (enb) prio_cpu <= dbg_win;
      if (enb && web == 4'b0) begin
        state   <= RD_WAIT;
        own_dbg <= dbg_win;
        cnt     <= CW'(RD_LAT);
      end
    end else if (state == RD_WAIT) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= DONE;
        if (own_dbg) dbg_rdata <= dob;
        else cpu_rdata <= dob;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 3;
  localparam int TO = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, dbg_req = 1'b0;
  logic [3:0] cpu_we = '0, dbg_we = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, enb;
  logic [31:0] cpu_rdata, dbg_rdata, dib, dob;
  logic [3:0] web;
  logic [ADDR_W-1:0] addrb;

  int vecs = 0;
  int errs = 0;
  logic [31:0] sh [4096];
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob)
  );

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  // BRAM environment: byte-write memory, read data valid exactly RD_LAT cycles after enb, junk otherwise
  logic [31:0] bram [4096];
  logic [31:0] pd [RD_LAT];
  logic [RD_LAT-1:0] pv = '0;
  logic [31:0] junk = 32'h0;
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 4096; i++) bram[i] <= init_val(i);
      filled <= 1'b1;
    end else if (enb) begin
      for (int b = 0; b < 4; b++) if (web[b]) bram[addrb][8*b+:8] <= dib[8*b+:8];
    end
    pd[0] <= bram[addrb];
    for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
    pv <= {pv[RD_LAT-2:0], enb && web == 4'b0};
    junk <= $urandom;
  end
  assign dob = pv[RD_LAT-1] ? pd[RD_LAT-1] : junk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  // reference model: a write updates the shadow memory, a read expects the current shadow word
  task automatic model(input bit is_dbg, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = word_of(a);
    if (we == 4'b0) begin
      if (is_dbg) dbg_q.push_back(sh[w]);
      else cpu_q.push_back(sh[w]);
    end else begin
      sh[w] = merge(sh[w], d, we);
    end
  endtask

  // monitor: pops the scoreboard on every rvalid and polices cpu_stall when no request
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid with rdata %h, expected none", cpu_rdata);
      end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL dbg_rvalid_unexpected: got rvalid with rdata %h, expected none", dbg_rdata);
      end else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
    end
    if (!cpu_req) chk("stall_no_req", {31'b0, cpu_stall}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    model(1'b0, we, a, d);
    @(negedge clk);
    while (cpu_stall && n < TO) begin n++; @(negedge clk); end
    if (n >= TO) begin
      vecs++; errs++;
      $display("FAIL cpu_timeout: got stall for %0d cycles, expected release", n);
    end else if (we != 4'b0) begin
      chk("cpu_wr_enb", {31'b0, enb}, 32'd1);
      chk("cpu_wr_addrb", {20'b0, addrb}, 32'(word_of(a)));
      chk("cpu_wr_web", {28'b0, web}, {28'b0, we});
      chk("cpu_wr_dib", dib, d);
    end
    step();
    cpu_req = 1'b0;
  endtask

  task automatic dbg_op(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
    model(1'b1, we, a, d);
    @(negedge clk);
    while (!dbg_gnt && n < TO) begin n++; @(negedge clk); end
    if (n >= TO) begin
      vecs++; errs++;
      $display("FAIL dbg_timeout: got no dbg_gnt in %0d cycles, expected grant", n);
    end else begin
      chk("dbg_enb", {31'b0, enb}, 32'd1);
      chk("dbg_addrb", {20'b0, addrb}, 32'(word_of(a)));
      chk("dbg_web", {28'b0, web}, {28'b0, we});
      chk("dbg_dib", dib, d);
    end
    step();
    dbg_req = 1'b0;
  endtask

  task automatic rand_we(output logic [3:0] we);
    we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] we;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) sh[i] = init_val(i);
    // reset: grant suppressed, stall follows cpu_req
    step(); step();
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h10; dbg_req = 1'b1;
    @(negedge clk);
    chk("rst_enb", {31'b0, enb}, 32'd0);
    chk("rst_web", {28'b0, web}, 32'd0);
    chk("rst_addrb", {20'b0, addrb}, 32'd0);
    chk("rst_dib", dib, 32'd0);
    chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
    step();
    cpu_req = 1'b0; dbg_req = 1'b0; rst = 1'b0;
    // CPU write granted combinationally, no stall
    step();
    cpu_req = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h104; cpu_wdata = 32'h0000BEEF;
    model(1'b0, 4'b0011, 32'h104, 32'h0000BEEF);
    @(negedge clk);
    chk("t1_enb", {31'b0, enb}, 32'd1);
    chk("t1_web", {28'b0, web}, 32'h3);
    chk("t1_addrb", {20'b0, addrb}, 32'h041);
    chk("t1_dib", dib, 32'h0000BEEF);
    chk("t1_stall", {31'b0, cpu_stall}, 32'd0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_enb_after", {31'b0, enb}, 32'd0);
    // upper address bits wrap modulo DMEM size
    step();
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'hFFFF_F008; cpu_wdata = 32'h12345678;
    model(1'b0, 4'hF, 32'hFFFF_F008, 32'h12345678);
    @(negedge clk);
    chk("t6_addrb", {20'b0, addrb}, 32'hC02);
    step();
    cpu_req = 1'b0;
    // CPU read latency and stall window
    cpu_op(4'hF, 32'h200, 32'hDEADBEEF);
    cpu_req = 1'b1; cpu_we = 4'b0; cpu_addr = 32'h200;
    model(1'b0, 4'b0, 32'h200, 32'h0);
    @(negedge clk);
    chk("t2_enb", {31'b0, enb}, 32'd1);
    chk("t2_addrb", {20'b0, addrb}, 32'h080);
    chk("t2_stall_grant", {31'b0, cpu_stall}, 32'd1);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk("t2_rvalid", {31'b0, cpu_rvalid}, 32'(k == RD_LAT + 1));
      chk("t2_stall", {31'b0, cpu_stall}, 32'(k != RD_LAT + 1));
      chk("t2_no_enb", {31'b0, enb}, 32'd0);
    end
    chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    cpu_req = 1'b0;
    // both requesters writing continuously alternate, CPU first after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h400; cpu_wdata = 32'h1111_0000;
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h2000; dbg_wdata = 32'h2222_0000;
    model(1'b0, 4'hF, 32'h400, 32'h1111_0000);
    model(1'b1, 4'hF, 32'h2000, 32'h2222_0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_dbg_gnt", {31'b0, dbg_gnt}, 32'(k % 2));
      chk("t3_stall", {31'b0, cpu_stall}, 32'(k % 2));
      chk("t3_addrb", {20'b0, addrb}, (k % 2 == 1) ? 32'h800 : 32'h100);
    end
    step();
    cpu_req = 1'b0; dbg_req = 1'b0;
    // debug read; CPU write arriving during RD_WAIT waits through DONE
    dbg_req = 1'b1; dbg_we = 4'b0; dbg_addr = 32'h3FFC;
    model(1'b1, 4'b0, 32'h3FFC, 32'h0);
    @(negedge clk);
    chk("t4_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("t4_addrb", {20'b0, addrb}, 32'hFFF);
    step();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'b1100; cpu_addr = 32'h44; cpu_wdata = 32'hCAFEF00D;
    model(1'b0, 4'b1100, 32'h44, 32'hCAFEF00D);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk("t4_stall", {31'b0, cpu_stall}, 32'd1);
      chk("t4_no_enb", {31'b0, enb}, 32'd0);
      chk("t4_dbg_rvalid", {31'b0, dbg_rvalid}, 32'(k == RD_LAT + 1));
    end
    @(negedge clk);
    chk("t4_cpu_enb", {31'b0, enb}, 32'd1);
    chk("t4_cpu_addrb", {20'b0, addrb}, 32'h011);
    chk("t4_cpu_web", {28'b0, web}, 32'hC);
    chk("t4_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    step();
    cpu_req = 1'b0;
    // reset during the last RD_WAIT cycle abandons the read
    cpu_req = 1'b1; cpu_we = 4'b0; cpu_addr = 32'h104;
    @(negedge clk);
    chk("t5_enb", {31'b0, enb}, 32'd1);
    repeat (RD_LAT) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      chk("t5_enb_rst", {31'b0, enb}, 32'd0);
      chk("t5_stall", {31'b0, cpu_stall}, 32'd1);
      if (k == 0) begin @(posedge clk); #1; end
    end
    step();
    rst = 1'b0; cpu_req = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    step();
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h808; cpu_wdata = 32'h5555AAAA;
    model(1'b0, 4'hF, 32'h808, 32'h5555AAAA);
    @(negedge clk);
    chk("t5_idle_enb", {31'b0, enb}, 32'd1);
    chk("t5_idle_stall", {31'b0, cpu_stall}, 32'd0);
    step();
    cpu_req = 1'b0;
    // randomized traffic: CPU in lower half of DMEM, debug in upper half
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          rand_we(we);
          a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 2047)) << 2) | 32'($urandom_range(0, 3));
          cpu_op(we, a, $urandom);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          rand_we(we);
          a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(2048, 4095)) << 2) | 32'($urandom_range(0, 3));
          dbg_op(we, a, $urandom);
        end
      end
    join
    repeat (RD_LAT + 4) @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
